// File: rtl/instr_issue_capture.sv
// Purpose: issues a loaded program into a fixed-latency pipeline and captures each result by program position.
// Latency: first launch 1 edge after start, done LATENCY edges after the last launch; res_data reads 1 cycle after res_addr.
// Backpressure: none. Issue is self-timed, and start/prog_we are ignored while busy.
//
// Ports:
//   i_clk, i_reset         rising-edge clock, synchronous active-high reset
//   i_prog_we/addr/data    program memory write port (IDLE/DONE only)
//   i_prog_len, i_start    run length (clamped to DEPTH) and run trigger
//   o_instruction          registered instruction to the processor (NOP_INSTR when idle)
//   i_result               processor result bus, sampled when a valid tag exits
//   o_busy, o_done         run status levels
//   o_res_count            results captured in the current run
//   i_res_addr, o_res_data registered read port of the result memory
module instr_issue_capture #(
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4,
    parameter int          LATENCY   = 4,
    parameter logic [7:0]  NOP_INSTR = 8'h00
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_prog_we,
    input  logic [AW-1:0] i_prog_addr,
    input  logic [7:0]    i_prog_data,
    input  logic [AW:0]   i_prog_len,
    input  logic          i_start,
    output logic [7:0]    o_instruction,
    input  logic [7:0]    i_result,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW:0]   o_res_count,
    input  logic [AW-1:0] i_res_addr,
    output logic [7:0]    o_res_data
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t        r_state;
    logic [7:0]    r_prog_mem [DEPTH];
    logic [7:0]    r_res_mem  [DEPTH];
    logic [AW:0]   r_len;
    logic [AW:0]   r_issue_ptr;
    logic [AW:0]   r_res_count;
    logic [7:0]    r_instruction;
    logic [7:0]    r_res_data;
    logic          r_busy;
    logic          r_done;

    // Tag shift register: one slot per pipeline stage; a valid tag names
    // the program position whose result is due when it leaves the last slot.
    logic [LATENCY-1:0] r_tag_vld;
    logic [AW-1:0]      r_tag_idx [LATENCY];

    logic          w_idle;
    logic          w_issue;
    logic          w_cap;
    logic [AW-1:0] w_cap_idx;
    logic [AW:0]   w_len_sel;
    logic          w_last_cap;

    assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_issue    = (r_state == S_ISSUE);
    assign w_cap      = r_tag_vld[LATENCY-1];
    assign w_cap_idx  = r_tag_idx[LATENCY-1];
    assign w_len_sel  = (i_prog_len > DEPTH_L) ? DEPTH_L : i_prog_len;
    assign w_last_cap = w_cap && ((r_res_count + 1'b1) == r_len);

    // Program memory has no reset; writes are accepted only between runs.
    always_ff @(posedge i_clk) begin
        if (w_idle && i_prog_we) begin
            r_prog_mem[i_prog_addr] <= i_prog_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_instruction <= NOP_INSTR;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_res_count   <= '0;
            r_res_data    <= '0;
            r_len         <= '0;
            r_issue_ptr   <= '0;
            r_tag_vld     <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_tag_idx[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                r_res_mem[i] <= '0;
            end
        end else begin
            r_res_data <= r_res_mem[i_res_addr];

            // A launch in ISSUE pushes a valid tag; every other slot is a NOP.
            r_tag_vld    <= {r_tag_vld[LATENCY-2:0], w_issue};
            r_tag_idx[0] <= r_issue_ptr[AW-1:0];
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_idx[i] <= r_tag_idx[i-1];
            end

            if (w_cap) begin
                r_res_mem[w_cap_idx] <= i_result;
                r_res_count          <= r_res_count + 1'b1;
            end

            unique case (r_state)
                S_IDLE, S_DONE: begin
                    r_instruction <= NOP_INSTR;
                    if (i_start) begin
                        // Tags are empty between runs, so the clear here never
                        // collides with a capture.
                        r_len       <= w_len_sel;
                        r_issue_ptr <= '0;
                        r_res_count <= '0;
                        for (int i = 0; i < DEPTH; i++) begin
                            r_res_mem[i] <= '0;
                        end
                        if (w_len_sel == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_instruction <= r_prog_mem[r_issue_ptr[AW-1:0]];
                    r_issue_ptr   <= r_issue_ptr + 1'b1;
                    if (r_issue_ptr == (r_len - 1'b1)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_instruction <= NOP_INSTR;
                    if (w_last_cap) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_instruction = r_instruction;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_res_count   = r_res_count;
    assign o_res_data    = r_res_data;

endmodule

// File: tb/tb_instr_issue_capture.sv
// Purpose: scoreboard bench for instr_issue_capture, using a fixed-latency processor stub.
// Latency: the stub returns instruction+1 so that it is sampled LATENCY edges after launch.
// Backpressure: none. Monitors pop expectations whenever an instruction or a done rise appears.
module tb_instr_issue_capture;

    localparam int AW      = 4;
    localparam int DEPTH   = 16;
    localparam int LATENCY = 4;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_prog_we = 1'b0;
    logic [AW-1:0] i_prog_addr = '0;
    logic [7:0]    i_prog_data = '0;
    logic [AW:0]   i_prog_len = '0;
    logic          i_start = 1'b0;
    logic [7:0]    o_instruction;
    logic [7:0]    i_result;
    logic          o_busy;
    logic          o_done;
    logic [AW:0]   o_res_count;
    logic [AW-1:0] i_res_addr = '0;
    logic [7:0]    o_res_data;

    always #5 clk = ~clk;

    instr_issue_capture #(.DEPTH(DEPTH), .AW(AW), .LATENCY(LATENCY), .NOP_INSTR(8'h00)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_prog_we(i_prog_we), .i_prog_addr(i_prog_addr),
        .i_prog_data(i_prog_data), .i_prog_len(i_prog_len), .i_start(i_start),
        .o_instruction(o_instruction), .i_result(i_result), .o_busy(o_busy), .o_done(o_done),
        .o_res_count(o_res_count), .i_res_addr(i_res_addr), .o_res_data(o_res_data)
    );

    // Processor stub: the instruction register is the first stage, and
    // LATENCY-1 further stages follow. The result is the instruction plus one.
    logic [7:0] stub_d [LATENCY-1];
    always @(posedge clk) begin
        stub_d[0] <= o_instruction;
        for (int i = 1; i < LATENCY-1; i++) stub_d[i] <= stub_d[i-1];
    end
    assign i_result = stub_d[LATENCY-2] + 8'd1;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int s_edge = 0;
    int done_cnt = 0;

    typedef struct { logic [7:0] val; int dly; } exp_instr_t;
    typedef struct { int dly; int cnt; } exp_done_t;
    exp_instr_t q_instr[$];
    exp_done_t  q_done[$];
    exp_instr_t mi;
    exp_done_t  md;
    logic       prev_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: checks each non-NOP instruction for value and launch edge,
    // and checks each rise of done for timing and result count.
    always @(negedge clk) begin
        if (!i_reset && o_instruction != 8'h00) begin
            if (q_instr.size() == 0) begin
                chk("unexpected_instr", int'(o_instruction), 0);
            end else begin
                mi = q_instr.pop_front();
                chk("instr_val", int'(o_instruction), int'(mi.val));
                chk("instr_time", edge_n - s_edge, mi.dly);
            end
        end
        if (o_done && !prev_done) begin
            done_cnt++;
            if (q_done.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                md = q_done.pop_front();
                chk("done_time", edge_n - s_edge, md.dly);
                chk("done_res_count", int'(o_res_count), md.cnt);
                chk("done_busy", int'(o_busy), 0);
            end
        end
        prev_done = o_done;
    end

    task automatic push_instr(input logic [7:0] v, input int d);
        exp_instr_t e;
        e.val = v; e.dly = d;
        q_instr.push_back(e);
    endtask

    task automatic push_done(input int d, input int c);
        exp_done_t e;
        e.dly = d; e.cnt = c;
        q_done.push_back(e);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        i_prog_we = 1'b1; i_prog_addr = a; i_prog_data = d;
        @(negedge clk);
        i_prog_we = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [7:0] exp, input string name);
        @(negedge clk);
        i_res_addr = a;
        @(negedge clk);
        chk(name, int'(o_res_data), int'(exp));
    endtask

    // Returns at the falling edge that follows start-sampling edge s.
    task automatic run_start(input logic [AW:0] len);
        @(negedge clk);
        i_start = 1'b1; i_prog_len = len;
        @(posedge clk);
        #1 s_edge = edge_n;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int c0;
        int n;
        c0 = done_cnt;
        n = 0;
        while (done_cnt == c0 && n < maxc) begin
            @(negedge clk);
            #1 n++;
        end
        if (done_cnt == c0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        chk("rst_instr", int'(o_instruction), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_res_count", int'(o_res_count), 0);
        chk("rst_res_data", int'(o_res_data), 0);

        // Basic three-instruction run.
        wr(0, 8'h12); wr(1, 8'h36); wr(2, 8'h83);
        push_instr(8'h12, 1); push_instr(8'h36, 2); push_instr(8'h83, 3);
        push_done(7, 3);
        run_start(3);
        wait_done(40);
        rd(0, 8'h13, "t1_res0"); rd(1, 8'h37, "t1_res1"); rd(2, 8'h84, "t1_res2");

        // Zero-length run from IDLE.
        @(negedge clk); #1 i_reset = 1'b1;
        @(negedge clk); i_reset = 1'b0;
        push_done(0, 0);
        run_start(0);
        chk("len0_done", int'(o_done), 1);
        repeat (4) begin
            @(negedge clk);
            chk("len0_busy", int'(o_busy), 0);
        end
        chk("len0_res_count", int'(o_res_count), 0);

        // Over-length run, clamped to DEPTH, with an ignored start and write mid-run.
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 8'h40 + 8'(i));
        for (int i = 0; i < DEPTH; i++) push_instr(8'h40 + 8'(i), i + 1);
        push_done(20, 16);
        run_start(20);
        @(negedge clk);
        i_start = 1'b1; i_prog_len = 3; i_prog_we = 1'b1; i_prog_addr = 0; i_prog_data = 8'hEE;
        @(negedge clk);
        i_start = 1'b0; i_prog_we = 1'b0;
        chk("busy_mid_run", int'(o_busy), 1);
        wait_done(60);
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), 8'h41 + 8'(i), "clamp_res");

        // Back-to-back run from DONE. Program entry 0 must still be 0x40.
        push_instr(8'h40, 1); push_instr(8'h41, 2);
        push_done(6, 2);
        run_start(2);
        chk("b2b_done_drop", int'(o_done), 0);
        rd(5, 8'h00, "b2b_cleared5");
        wait_done(30);
        rd(0, 8'h41, "b2b_res0"); rd(1, 8'h42, "b2b_res1"); rd(2, 8'h00, "b2b_res2_clear");

        // Reset sampled at edge s+3 of a 16-long run.
        push_instr(8'h40, 1); push_instr(8'h41, 2);
        run_start(16);
        @(negedge clk);
        @(negedge clk);
        #1 i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        chk("mid_rst_instr", int'(o_instruction), 0);
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_done", int'(o_done), 0);
        chk("mid_rst_res_count", int'(o_res_count), 0);
        chk("mid_rst_instr_q", q_instr.size(), 0);
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), 8'h00, "mid_rst_res");

        // Fresh run after reset.
        push_instr(8'h40, 1); push_instr(8'h41, 2); push_instr(8'h42, 3);
        push_done(7, 3);
        run_start(3);
        wait_done(40);
        rd(0, 8'h41, "fresh_res0"); rd(1, 8'h42, "fresh_res1"); rd(2, 8'h43, "fresh_res2");

        repeat (3) @(negedge clk);
        chk("instr_q_empty", q_instr.size(), 0);
        chk("done_q_empty", q_done.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
